// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset core.
// Moore FSM with registered outputs, plus the ALU and immediate decoders.
module multicycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       regWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic [2:0] aluControl,
  output logic [3:0] state,
  output logic       instrDone,
  output logic       halted
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcupd;
    logic       branch;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       done;
    logic       halt;
  } ctl_t;

  state_t st;
  ctl_t   c;

  function automatic state_t step(
    input state_t     s,
    input logic [6:0] o
  );
    state_t n;
    case (s)
      FETCH:    n = DECODE;
      DECODE: begin
        case (o)
          OP_LW,
          OP_SW:   n = MEMADR;
          OP_R:    n = EXECUTER;
          OP_I:    n = EXECUTEI;
          OP_JAL:  n = JAL;
          OP_BEQ:  n = BEQ;
          default: n = HALT_ON_ILLEGAL ? HALT : FETCH;
        endcase
      end
      MEMADR:   n = (o == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = MEMWB;
      EXECUTER: n = ALUWB;
      EXECUTEI: n = ALUWB;
      JAL:      n = ALUWB;
      MEMWB:    n = FETCH;
      MEMWRITE: n = FETCH;
      ALUWB:    n = FETCH;
      BEQ:      n = FETCH;
      HALT:     n = HALT;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  function automatic ctl_t ctl(input state_t s);
    ctl_t k;
    k = '0;
    case (s)
      FETCH: begin
        k.irwrite   = 1'b1;
        k.alusrcb   = 2'b10;
        k.resultsrc = 2'b10;
        k.pcupd     = 1'b1;
      end
      DECODE: begin
        k.alusrca = 2'b01;
        k.alusrcb = 2'b01;
      end
      MEMADR: begin
        k.alusrca = 2'b10;
        k.alusrcb = 2'b01;
      end
      MEMREAD:  k.adrsrc = 1'b1;
      MEMWB: begin
        k.resultsrc = 2'b01;
        k.regwrite  = 1'b1;
        k.done      = 1'b1;
      end
      MEMWRITE: begin
        k.adrsrc   = 1'b1;
        k.memwrite = 1'b1;
        k.done     = 1'b1;
      end
      EXECUTER: begin
        k.alusrca = 2'b10;
        k.aluop   = 2'b10;
      end
      EXECUTEI: begin
        k.alusrca = 2'b10;
        k.alusrcb = 2'b01;
        k.aluop   = 2'b10;
      end
      ALUWB: begin
        k.regwrite = 1'b1;
        k.done     = 1'b1;
      end
      JAL: begin
        k.alusrca = 2'b01;
        k.alusrcb = 2'b10;
        k.pcupd   = 1'b1;
      end
      BEQ: begin
        k.alusrca = 2'b10;
        k.aluop   = 2'b01;
        k.branch  = 1'b1;
        k.done    = 1'b1;
      end
      HALT:     k.halt = 1'b1;
      default:  k = '0;
    endcase
    return k;
  endfunction

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= FETCH;
      c  <= ctl(FETCH);
    end else begin
      st <= step(st, op);
      c  <= ctl(step(st, op));
    end
  end

  assign pcWrite   = ~reset & (c.pcupd | (c.branch & zero));
  assign irWrite   = ~reset & c.irwrite;
  assign memWrite  = ~reset & c.memwrite;
  assign regWrite  = ~reset & c.regwrite;
  assign adrSrc    = c.adrsrc;
  assign resultSrc = c.resultsrc;
  assign aluSrcA   = c.alusrca;
  assign aluSrcB   = c.alusrcb;
  assign instrDone = c.done;
  assign halted    = c.halt;
  assign state     = st;

  always_comb begin
    aluControl = 3'b000;
    case (c.aluop)
      2'b01: aluControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  aluControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  aluControl = 3'b101;
          3'b110:  aluControl = 3'b011;
          3'b111:  aluControl = 3'b010;
          default: aluControl = 3'b000;
        endcase
      end
      default: aluControl = 3'b000;
    endcase
  end

  always_comb begin
    immSrc = 2'b00;
    unique case (1'b1)
      (op == OP_SW):  immSrc = 2'b01;
      (op == OP_BEQ): immSrc = 2'b10;
      (op == OP_JAL): immSrc = 2'b11;
      default:        immSrc = 2'b00;
    endcase
  end

endmodule
